// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, request codes and baud helper
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    localparam logic [7:0] REQ_STATUS = 8'd3;
    localparam logic [7:0] REQ_TEMP   = 8'd4;
    localparam logic [7:0] REQ_HUM    = 8'd5;
    localparam logic [7:0] ERR_CRC    = 8'd31;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period counter with one-cycle bit_end strobe
// Counter is held at zero while disabled so every enabled run starts a full bit.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic i_en,
    output logic o_bit_end
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;

    assign o_bit_end = i_en && (r_cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (!i_en || o_bit_end) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter, 8 data bits LSB-first, 1 stop bit
// Define UART_TX_PARITY_EN for a parity bit (even/odd per PARITY_ODD); default is 8N1.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int PARITY_ODD = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       i_start_tx,
    input  logic [7:0] i_dados_8,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);

    tx_state_t  r_state, w_state_next;
    logic [7:0] r_shift, w_shift_next;
    logic [2:0] r_bit_cnt, w_bit_next;
    logic       r_start_q, r_tx, r_busy, r_done;
    logic       w_tx_next, w_done_next;
    logic       w_edge, w_bit_end;

`ifdef UART_TX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
    logic [7:0] r_data, w_data_next;
    logic       w_parity;
    assign w_parity = (^r_data) ^ ODD;
`else
    logic w_unused_cfg;
    assign w_unused_cfg = (PARITY_ODD != 0);
`endif

    assign w_edge = i_start_tx & ~r_start_q;
    assign o_tx   = r_tx;
    assign o_busy = r_busy;
    assign o_done = r_done;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clock    (clock),
        .reset    (reset),
        .i_en     (r_state != ST_IDLE),
        .o_bit_end(w_bit_end)
    );

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_bit_next   = r_bit_cnt;
        w_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_data_next  = r_data;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_next = ST_START;
                    w_shift_next = i_dados_8;
                    w_bit_next   = 3'd0;
`ifdef UART_TX_PARITY_EN
                    w_data_next  = i_dados_8;
`endif
                end
            end
            ST_START: begin
                if (w_bit_end) w_state_next = ST_DATA;
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shift_next = r_shift >> 1;
                    if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) w_state_next = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // Line level is decoded from the next state so o_tx can be a plain register.
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_parity;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_start_q <= 1'b0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_data    <= '0;
`endif
        end else begin
            r_state   <= w_state_next;
            r_shift   <= w_shift_next;
            r_bit_cnt <= w_bit_next;
            r_start_q <= i_start_tx;
            r_tx      <= w_tx_next;
            r_busy    <= (w_state_next != ST_IDLE);
            r_done    <= w_done_next;
`ifdef UART_TX_PARITY_EN
            r_data    <= w_data_next;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - directed scoreboard bench for uart_tx (CLKS_PER_BIT=10)
// Define UART_TX_PARITY_EN to add the parity frames and an odd-parity instance.
module tb_uart_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       i_start_tx = 1'b0;
    logic [7:0] i_dados_8 = 8'h00;
    logic       o_tx, o_busy, o_done;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
    logic o_tx_odd, o_busy_odd, o_done_odd;
    uart_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY_ODD(1)) dut_odd (
        .clock(clock), .reset(reset), .i_start_tx(i_start_tx), .i_dados_8(i_dados_8),
        .o_tx(o_tx_odd), .o_busy(o_busy_odd), .o_done(o_done_odd)
    );
`else
    localparam int NBITS = 10;
`endif

    uart_tx #(.CLK_FREQ(1000), .BAUD(100), .PARITY_ODD(0)) dut (
        .clock(clock), .reset(reset), .i_start_tx(i_start_tx), .i_dados_8(i_dados_8),
        .o_tx(o_tx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Caller has already raised i_start_tx; the next posedge accepts the edge.
    task automatic run_frame(input logic [7:0] d, input int release_k, input int poke_k,
                             input logic chain, input logic [7:0] next_d);
        logic [7:0] rx;
        logic [7:0] exp_d;
        int b;
        rx = '0;
        exp_q.push_back(d);
        tick();
        for (int k = 0; k < NBITS * 10; k++) begin
            if (k > 0) tick();
            if (k == release_k) i_start_tx = 1'b0;
            if (k == poke_k) begin
                i_start_tx = 1'b1;
                i_dados_8  = 8'hFF;
            end
            if (k == 0) begin
                chk("start_first", o_tx, 8'd0);
                chk("busy_on", o_busy, 8'd1);
            end
            if (k == 9)  chk("start_last", o_tx, 8'd0);
            if (k == 10) chk("bit0_first", o_tx, d[0]);
            if (k % 10 == 5) begin
                b = k / 10;
                if (b == 0) begin
                    chk("start_mid", o_tx, 8'd0);
                end else if (b <= 8) begin
                    rx[b-1] = o_tx;
                    chk("data_mid", o_tx, d[b-1]);
                end else if (b == NBITS - 1) begin
                    chk("stop_mid", o_tx, 8'd1);
                    chk("busy_stop", o_busy, 8'd1);
                end else begin
`ifdef UART_TX_PARITY_EN
                    chk("parity_even", o_tx, ^d);
                    chk("parity_odd", o_tx_odd, ~^d);
`endif
                end
            end
            if (k == NBITS * 10 - 1) chk("no_early_done", o_done, 8'd0);
        end
        tick();
        chk("done_pulse", o_done, 8'd1);
        chk("idle_tx", o_tx, 8'd1);
        chk("busy_off", o_busy, 8'd0);
        exp_d = exp_q.pop_front();
        chk("sb_byte", rx, exp_d);
        if (chain) begin
            i_dados_8  = next_d;
            i_start_tx = 1'b1;
        end else begin
            tick();
            chk("done_one_cycle", o_done, 8'd0);
        end
    endtask

    task automatic idle_check(input int n, input string tag);
        int lows, busys, dones;
        lows = 0; busys = 0; dones = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_tx !== 1'b1) lows++;
            if (o_busy !== 1'b0) busys++;
            if (o_done !== 1'b0) dones++;
        end
        chk({tag, "_tx_low"}, 8'(lows), 8'd0);
        chk({tag, "_busy"}, 8'(busys), 8'd0);
        chk({tag, "_done"}, 8'(dones), 8'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("rst_tx", o_tx, 8'd1);
        chk("rst_busy", o_busy, 8'd0);
        chk("rst_done", o_done, 8'd0);
        reset = 1'b0;
        idle_check(5, "post_rst");

        // 1: 0x55
        i_dados_8 = 8'h55; i_start_tx = 1'b1;
        run_frame(8'h55, 20, -1, 1'b0, 8'h00);
        idle_check(5, "t1_idle");

        // 2: held start sends exactly one frame
        i_dados_8 = 8'hA3; i_start_tx = 1'b1;
        run_frame(8'hA3, -1, -1, 1'b0, 8'h00);
        idle_check(500 - NBITS * 10 - 2, "t2_held");
        i_start_tx = 1'b0;
        tick();

        // 3: mid-frame edge with 0xFF is dropped
        i_dados_8 = 8'h3C; i_start_tx = 1'b1;
        run_frame(8'h3C, 20, 39, 1'b0, 8'h00);
        idle_check(20, "t3_after");
        i_start_tx = 1'b0;
        tick();

        // 4: reset mid-frame
        i_dados_8 = 8'hC9; i_start_tx = 1'b1;
        tick();
        chk("t4_started", o_tx, 8'd0);
        repeat (33) tick();
        #2;
        reset = 1'b1; i_start_tx = 1'b0;
        #1;
        chk("t4_rst_tx", o_tx, 8'd1);
        chk("t4_rst_busy", o_busy, 8'd0);
        tick(); tick();
        reset = 1'b0;
        idle_check(30, "t4_released");
        i_dados_8 = 8'h96; i_start_tx = 1'b1;
        run_frame(8'h96, 5, -1, 1'b0, 8'h00);

        // 5: back-to-back frames, edge on the o_done cycle
        i_dados_8 = 8'h04; i_start_tx = 1'b1;
        run_frame(8'h04, 50, -1, 1'b1, 8'h1F);
        run_frame(8'h1F, 5, -1, 1'b0, 8'h00);
        idle_check(10, "t5_idle");

`ifdef UART_TX_PARITY_EN
        // 6: parity frame for 0x07
        i_dados_8 = 8'h07; i_start_tx = 1'b1;
        run_frame(8'h07, 5, -1, 1'b0, 8'h00);
        idle_check(5, "t6_idle");
`endif

        chk("sb_empty", 8'(exp_q.size()), 8'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
